bin2bcd_conv: RTL and testbench
===============================

BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 Parameter BIN_W, default 32, width of the unsigned binary input; legal range 4..32.
REQ-002 Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  conversion request, sampled on the rising edge of Clk.
REQ-005 Bin  input  BIN_W  unsigned binary value, captured when a Start is accepted.
REQ-006 Busy  output  1  high while a conversion is in progress.
REQ-007 Done  output  1  one-cycle pulse marking that a new result is valid.
REQ-008 Bcd  output  32  packed 8421 BCD result, 8 digits; Bcd[31:28] is the most significant digit and Bcd[3:0] the least, ready to drive the 8-digit scanned display as its N input.
REQ-009 Ovf  output  1  high when the converted value exceeds 99_999_999.

Function
REQ-010 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-011 In IDLE or DONE, a Start sampled high at edge E0 SHALL capture Bin, clear the 40-bit (10-digit) internal BCD accumulator, clear the iteration counter, and enter SHIFT.
REQ-012 In SHIFT, each edge SHALL perform one double-dabble iteration.
- Step 1: add 3 to every accumulator digit that is >= 5.
- Step 2: shift {accumulator, binary} left by 1; the binary MSB enters accumulator bit 0.
REQ-013 Iterations SHALL occur at edges E0+1 through E0+BIN_W; the counter SHALL be wide enough for BIN_W and SHALL NOT wrap early.
REQ-014 After the BIN_W-th iteration, the FSM SHALL enter DONE at edge E0+BIN_W+1, which SHALL load the outputs as follows:
- Bcd = accumulator[31:0].
- Ovf = 1 if accumulator[39:32] is nonzero, otherwise 0.
REQ-015 Done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return the FSM to IDLE unless Start is high at that edge.
REQ-016 Busy SHALL be high in SHIFT only; Busy and Done SHALL never be high in the same cycle.
REQ-017 Latency SHALL be fixed: Done is observed high in the cycle after edge E0+BIN_W+1, i.e. BIN_W+1 cycles after the accepting edge, independent of data.
REQ-018 A Start received while in SHIFT SHALL be ignored; the conversion in progress SHALL NOT be disturbed, and Bin changes during SHIFT SHALL have no effect.
REQ-019 A Start received in DONE SHALL be accepted exactly as in IDLE (back-to-back conversions, one idle-free cycle between them).
REQ-020 Bcd and Ovf SHALL hold their last result until the next DONE and SHALL NOT change during SHIFT.
REQ-021 Each digit of Bcd SHALL always be in the range 0..9; no hex digit A..F shall appear.
REQ-022 On overflow, Bcd SHALL carry the low 8 decimal digits of the value; no saturation is applied.

Reset
REQ-023 When Rst_n is low, the following SHALL hold immediately, independent of Clk:
- FSM in IDLE.
- Busy=0, Done=0, Bcd=32'h0, Ovf=0.
- Accumulator, binary shift register and iteration counter cleared.
REQ-024 Reset asserted during SHIFT SHALL abort the conversion; after release, no Done SHALL appear until a new Start is accepted.
REQ-025 The first edge with Rst_n high SHALL be able to accept a Start.

Verification
REQ-026 Start with Bin=0 -> Done 33 cycles later, Bcd=0x00000000, Ovf=0.
REQ-027 Bin=0x00BC614E (12345678) -> Bcd=0x12345678, Ovf=0; Bin=0x05F5E0FF (99999999) -> Bcd=0x99999999, Ovf=0.
REQ-028 Bin=0x05F5E100 (100000000) -> Bcd=0x00000000, Ovf=1; Bin=0xFFFFFFFF -> Bcd=0x94967295, Ovf=1.
REQ-029 Start pulse while Busy, with Bin changed to 5 -> single Done at the original latency, with the first value's result; no second Done.
REQ-030 Rst_n pulsed low 10 cycles into a conversion of 12345678 -> outputs 0 at once; no Done afterward; a new Start for 42 gives Bcd=0x00000042.
REQ-031 Start held high continuously -> Done every 34 cycles, Busy low only in DONE cycles, and Bcd matching each captured Bin.

Source files
------------

// File: rtl/bin2bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_conv
// Description : Sequential binary-to-BCD converter using the double-dabble
//               algorithm. One iteration per clock. The result is presented
//               as 8 packed 8421 BCD digits plus an overflow flag for
//               values above 99_999_999.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_conv #(
    // Width of the unsigned binary input, 4..32
    parameter int BIN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [31:0]      bcd,
    output logic             ovf
);

    // The counter must be able to hold the value BIN_W itself, because
    // SHIFT stays one extra edge after the last iteration before DONE.
    localparam int               CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);
    localparam int               DIGITS   = 10;
    localparam int               ACC_W    = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [BIN_W-1:0]   bin_sr;
    logic [CNT_W-1:0]   cnt;

    // Accumulator after the "add 3 to digits >= 5" step. Only bits 38:0 are
    // kept because bit 39 is shifted out on the same iteration.
    logic [ACC_W-2:0]   acc_adj;

    // Digits 0..8 take the usual conditional +3 correction.
    for (genvar d = 0; d < DIGITS - 1; d++) begin : g_digit
        assign acc_adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? (acc[4*d +: 4] + 4'd3)
                                                           : acc[4*d +: 4];
    end

    // The top digit never reaches 5: the largest input, 2^32-1, is below
    // 5_000_000_000, so at every iteration the partial value keeps digit 9
    // at 4 or less and it needs no correction.
    assign acc_adj[ACC_W-2:ACC_W-4] = acc[ACC_W-2:ACC_W-4];

    // Control FSM, datapath and registered outputs in one sequential block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            bin_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= 32'h0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Accept a new request: capture operand and restart.
                        bin_sr <= bin;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        // All BIN_W iterations done: publish the result.
                        bcd   <= acc[31:0];
                        ovf   <= |acc[ACC_W-1:32];
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // One double-dabble iteration: correct then shift.
                        acc    <= {acc_adj, bin_sr[BIN_W-1]};
                        bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                        cnt    <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_conv
// Description : Self-checking bench for bin2bcd_conv. A decimal reference
//               model built from integer division supplies every expected
//               result; directed and random operands are converted in turn.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_conv;

    localparam int BIN_W   = 32;
    localparam int LATENCY = BIN_W + 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;

    int          n_vec;
    int          n_err;
    logic [31:0] last_bcd;
    logic        last_ovf;

    bin2bcd_conv #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decimal reference: low 8 decimal digits plus an overflow flag.
    function automatic logic [32:0] model(input logic [31:0] v);
        longint unsigned x;
        logic [31:0]     r;
        x = 64'(v);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {(64'(v) > 64'd99999999), r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following
    // the accepting edge, with start released and bin scrambled.
    task automatic start_conv(input logic [31:0] v);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = $urandom;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("done_after_accept", 64'(done), 64'd0);
    endtask

    // Waits for Done, checking busy and held outputs every SHIFT cycle.
    // A one-cycle Start with bin=5 is injected at cycle pulse_at (if >0).
    task automatic wait_done(input logic [31:0] v, input int pulse_at, input bit keep_start);
        logic [32:0] m;
        int          lat;
        bit          seen;
        m    = model(v);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                chk("busy_in_shift", 64'(busy), 64'd1);
                chk("hold_bcd", 64'(bcd), 64'(last_bcd));
                chk("hold_ovf", 64'(ovf), 64'(last_ovf));
            end
            if (!keep_start) begin
                if (lat == pulse_at) begin
                    start = 1'b1;
                    bin   = 32'd5;
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(LATENCY));
        chk("bcd", 64'(bcd), 64'(m[31:0]));
        chk("ovf", 64'(ovf), 64'(m[32]));
        chk("busy_in_done", 64'(busy), 64'd0);
        last_bcd = m[31:0];
        last_ovf = m[32];
    endtask

    // Full conversion followed by the return to IDLE.
    task automatic run_conv(input logic [31:0] v);
        start_conv(v);
        wait_done(v, 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("done_drops", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        int          n_done;
        int          n_busy;

        n_vec    = 0;
        n_err    = 0;
        last_bcd = '0;
        last_ovf = 1'b0;
        rst_n    = 1'b1;
        start    = 1'b0;
        bin      = '0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner values.
        run_conv(32'd0);
        run_conv(32'h00BC614E);
        run_conv(32'h05F5E0FF);
        run_conv(32'h05F5E100);
        run_conv(32'hFFFFFFFF);
        run_conv(32'd9);
        run_conv(32'd10);

        // Random operands, both full-range and within 8 digits.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) run_conv($urandom);
            else            run_conv($urandom_range(0, 99999999));
        end

        // Start pulse with a new operand while busy must be ignored.
        start_conv(32'd12345678);
        wait_done(32'd12345678, 5, 1'b0);
        start  = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("no_second_done", 64'(n_done), 64'd0);

        // Reset in the middle of a conversion aborts it.
        start_conv(32'd12345678);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_bcd", 64'(bcd), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        last_bcd = '0;
        last_ovf = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        n_busy = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_no_busy", 64'(n_busy), 64'd0);
        run_conv(32'd42);
        chk("bcd_42", 64'(bcd), 64'h42);

        // Start on the very first edge after reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        last_bcd = '0;
        last_ovf = 1'b0;
        run_conv(32'd87654321);

        // Start held high: back-to-back conversions, one DONE cycle apart.
        for (int i = 0; i < 5; i++) q.push_back($urandom);
        start = 1'b1;
        bin   = q[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("held_busy", 64'(busy), 64'd1);
            chk("held_done", 64'(done), 64'd0);
            bin = q[i+1];
            wait_done(q[i], 0, 1'b1);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("held_end_done", 64'(done), 64'd0);
        chk("held_end_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
